// File: rtl/npu_res_checker.sv
`default_nettype none
// ============================================================================
// Module   : npu_res_checker
// Brief    : Lane-wise on-line checker of NPU output writes against golden
//            words, with statistics and first-failure capture. Defining
//            NPU_CHK_LOG_EN adds capture of the first failing word pair.
// Revision : 1.0 - initial release
// ============================================================================
module npu_res_checker #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int REF_LAT = 1,
    parameter int CW      = 16
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_end,
    input  logic                 i_stop_on_err,
    input  logic                 i_wr,
    input  logic                 i_wrh,
    input  logic                 i_wrh_l_n,
    input  logic [N*W-1:0]       i_dut,
    input  logic [N*W-1:0]       i_ref,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_halt,
    output logic                 o_err,
    output logic [CW-1:0]        o_chk_cnt,
    output logic [CW-1:0]        o_err_cnt,
    output logic [CW-1:0]        o_first_beat,
    output logic [$clog2(W)-1:0] o_first_lane,
    output logic [N*W-1:0]       o_log_ref,
    output logic [N*W-1:0]       o_log_dut
);

    localparam int LW = $clog2(W);
    localparam int SW = CW + LW + 1;
    localparam logic [CW-1:0] c_CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            w_active, w_arm, w_flush;
    logic            w_s_v, w_d_v, w_dly_busy, w_pipe_empty;
    logic [W-1:0]    w_s_mask, w_d_mask, w_mm_nxt;
    logic [N*W-1:0]  w_d_dut;
    logic            r_c_v;
    logic [W-1:0]    r_c_mm;
    logic            w_acc, w_hit;
    logic [LW:0]     w_pop;
    logic [LW-1:0]   w_lane;
    logic [SW-1:0]   w_err_sum;
    logic [CW-1:0]   w_err_sat;
    logic            r_err;
    logic [CW-1:0]   r_chk_cnt, r_err_cnt, r_first_beat;
    logic [LW-1:0]   r_first_lane;

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_arm    = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_HALT);
    assign w_flush  = (r_state == S_HALT);
    assign w_s_v    = i_wr && (r_state == S_RUN);

    // Mask bit k covers lane k; lane 0 sits in the MSBs of the word.
    always_comb begin
        w_s_mask = '1;
        if (i_wrh) begin
            w_s_mask = i_wrh_l_n ? {{(W/2){1'b1}}, {(W/2){1'b0}}}
                                 : {{(W/2){1'b0}}, {(W/2){1'b1}}};
        end
    end

    generate
        if (REF_LAT == 0) begin : g_lat0
            assign w_d_v      = w_s_v;
            assign w_d_mask   = w_s_mask;
            assign w_d_dut    = i_dut;
            assign w_dly_busy = 1'b0;
        end else begin : g_lat
            logic [REF_LAT-1:0] r_dv;
            logic [W-1:0]       r_dmask [REF_LAT];
            logic [N*W-1:0]     r_ddut  [REF_LAT];

            always_ff @(posedge ck or negedge rst_n) begin
                if (!rst_n) begin
                    r_dv <= '0;
                    for (int i = 0; i < REF_LAT; i++) begin
                        r_dmask[i] <= '0;
                        r_ddut[i]  <= '0;
                    end
                end else begin
                    r_dv[0]    <= w_s_v;
                    r_dmask[0] <= w_s_mask;
                    r_ddut[0]  <= i_dut;
                    for (int i = 1; i < REF_LAT; i++) begin
                        r_dv[i]    <= r_dv[i-1] & ~w_flush;
                        r_dmask[i] <= r_dmask[i-1];
                        r_ddut[i]  <= r_ddut[i-1];
                    end
                end
            end

            assign w_d_v      = r_dv[REF_LAT-1];
            assign w_d_mask   = r_dmask[REF_LAT-1];
            assign w_d_dut    = r_ddut[REF_LAT-1];
            assign w_dly_busy = |r_dv;
        end
    endgenerate

    always_comb begin
        w_mm_nxt = '0;
        for (int k = 0; k < W; k++) begin
            w_mm_nxt[k] = w_d_mask[k] && (w_d_dut[N*W-1-k*N -: N] != i_ref[N*W-1-k*N -: N]);
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_c_v  <= 1'b0;
            r_c_mm <= '0;
        end else if (w_flush) begin
            r_c_v  <= 1'b0;
            r_c_mm <= '0;
        end else begin
            r_c_v  <= w_d_v;
            r_c_mm <= w_d_v ? w_mm_nxt : '0;
        end
    end

    always_comb begin
        w_pop  = '0;
        w_lane = '0;
        for (int k = W - 1; k >= 0; k--) begin
            w_pop = w_pop + (LW+1)'(r_c_mm[k]);
            if (r_c_mm[k]) begin
                w_lane = LW'(k);
            end
        end
    end

    assign w_acc        = r_c_v && w_active;
    assign w_hit        = w_acc && (|r_c_mm);
    assign w_pipe_empty = !w_dly_busy && !r_c_v;
    assign w_err_sum    = SW'(r_err_cnt) + SW'(w_pop);
    assign w_err_sat    = (w_err_sum > SW'(c_CNT_MAX)) ? c_CNT_MAX : w_err_sum[CW-1:0];

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A stopping mismatch takes priority over every other exit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_HALT: if (i_start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_hit && i_stop_on_err) w_state_nxt = S_HALT;
                else if (i_end)             w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_hit && i_stop_on_err) w_state_nxt = S_HALT;
                else if (w_pipe_empty)      w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_err        <= 1'b0;
            r_chk_cnt    <= '0;
            r_err_cnt    <= '0;
            r_first_beat <= '0;
            r_first_lane <= '0;
        end else if (w_arm) begin
            r_err        <= 1'b0;
            r_chk_cnt    <= '0;
            r_err_cnt    <= '0;
            r_first_beat <= '0;
            r_first_lane <= '0;
        end else if (w_acc) begin
            if (r_chk_cnt != c_CNT_MAX) r_chk_cnt <= r_chk_cnt + 1'b1;
            r_err_cnt <= w_err_sat;
            if (w_hit) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_first_beat <= r_chk_cnt;
                    r_first_lane <= w_lane;
                end
            end
        end
    end

`ifdef NPU_CHK_LOG_EN
    logic [N*W-1:0] r_c_dut, r_c_ref, r_log_dut, r_log_ref;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_c_dut   <= '0;
            r_c_ref   <= '0;
            r_log_dut <= '0;
            r_log_ref <= '0;
        end else begin
            r_c_dut <= w_d_dut;
            r_c_ref <= i_ref;
            if (w_arm) begin
                r_log_dut <= '0;
                r_log_ref <= '0;
            end else if (w_hit && !r_err) begin
                r_log_dut <= r_c_dut;
                r_log_ref <= r_c_ref;
            end
        end
    end

    assign o_log_dut = r_log_dut;
    assign o_log_ref = r_log_ref;
`else
    assign o_log_dut = '0;
    assign o_log_ref = '0;
`endif

    assign o_busy       = w_active;
    assign o_done       = (r_state == S_DONE);
    assign o_halt       = (r_state == S_HALT);
    assign o_err        = r_err;
    assign o_chk_cnt    = r_chk_cnt;
    assign o_err_cnt    = r_err_cnt;
    assign o_first_beat = r_first_beat;
    assign o_first_lane = r_first_lane;

endmodule
`default_nettype wire

// File: tb/tb_npu_res_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_npu_res_checker
// Brief    : Directed bench for npu_res_checker (CW=16 and CW=4 instances)
//            with a cycle-level behavioural model and literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_npu_res_checker;

    localparam int N = 4, W = 8, LAT = 1, CWA = 16, CWB = 4, DW = N * W;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3, M_HALT = 4;

    logic ck = 1'b0, rst_n = 1'b0;
    logic i_start = 1'b0, i_end = 1'b0, i_stop_on_err = 1'b0;
    logic i_wr = 1'b0, i_wrh = 1'b0, i_wrh_l_n = 1'b0;
    logic [DW-1:0] i_dut = '0, i_ref = '0;

    logic o_busy_a, o_done_a, o_halt_a, o_err_a;
    logic [CWA-1:0] o_chk_a, o_errc_a, o_fbeat_a;
    logic [2:0] o_flane_a;
    logic [DW-1:0] o_lref_a, o_ldut_a;
    logic o_busy_b, o_done_b, o_halt_b, o_err_b;
    logic [CWB-1:0] o_chk_b, o_errc_b, o_fbeat_b;
    logic [2:0] o_flane_b;
    logic [DW-1:0] o_lref_b, o_ldut_b;

    npu_res_checker #(.N(N), .W(W), .REF_LAT(LAT), .CW(CWA)) u_dut_a (
        .ck(ck), .rst_n(rst_n), .i_start(i_start), .i_end(i_end),
        .i_stop_on_err(i_stop_on_err), .i_wr(i_wr), .i_wrh(i_wrh), .i_wrh_l_n(i_wrh_l_n),
        .i_dut(i_dut), .i_ref(i_ref), .o_busy(o_busy_a), .o_done(o_done_a),
        .o_halt(o_halt_a), .o_err(o_err_a), .o_chk_cnt(o_chk_a), .o_err_cnt(o_errc_a),
        .o_first_beat(o_fbeat_a), .o_first_lane(o_flane_a),
        .o_log_ref(o_lref_a), .o_log_dut(o_ldut_a));

    npu_res_checker #(.N(N), .W(W), .REF_LAT(LAT), .CW(CWB)) u_dut_b (
        .ck(ck), .rst_n(rst_n), .i_start(i_start), .i_end(i_end),
        .i_stop_on_err(i_stop_on_err), .i_wr(i_wr), .i_wrh(i_wrh), .i_wrh_l_n(i_wrh_l_n),
        .i_dut(i_dut), .i_ref(i_ref), .o_busy(o_busy_b), .o_done(o_done_b),
        .o_halt(o_halt_b), .o_err(o_err_b), .o_chk_cnt(o_chk_b), .o_err_cnt(o_errc_b),
        .o_first_beat(o_fbeat_b), .o_first_lane(o_flane_b),
        .o_log_ref(o_lref_b), .o_log_dut(o_ldut_b));

    always #5 ck = ~ck;

    int n_tot = 0, n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] sat(input int v, input int cw);
        int mx;
        mx = (1 << cw) - 1;
        return 64'((v > mx) ? mx : v);
    endfunction

    function automatic logic [63:0] exp_log(input logic [DW-1:0] v);
`ifdef NPU_CHK_LOG_EN
        return 64'(v);
`else
        return 64'd0 & 64'(v);
`endif
    endfunction

    function automatic int lane(input logic [DW-1:0] x, input int k);
        logic [DW-1:0] t;
        t = x >> (DW - N * (k + 1));
        return int'(t[N-1:0]);
    endfunction

    function automatic bit in_half(input logic wrh, input logic ln, input int k);
        if (!wrh) return 1'b1;
        if (ln) return k >= W / 2;
        return k < W / 2;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [DW-1:0] r;
        logic          wrh;
        logic          ln;
        int            due;
    } beat_t;

    beat_t mq[$];
    int m_mode = M_IDLE, m_chk = 0, m_errc = 0, m_fbeat = 0, m_flane = 0, cyc = 0;
    bit m_err = 1'b0;
    logic [DW-1:0] m_ldut = '0, m_lref = '0;
    logic [DW-1:0] tb_ref_now = '0, ref_pipe = '0;

    initial begin : model
        beat_t b;
        int e, fl;
        bit halt, empty;
        forever begin
            @(posedge ck or negedge rst_n);
            if (!rst_n) begin
                m_mode = M_IDLE; m_chk = 0; m_errc = 0; m_fbeat = 0; m_flane = 0;
                m_err = 1'b0; m_ldut = '0; m_lref = '0;
                mq.delete();
            end else begin
                cyc++;
                halt  = 1'b0;
                empty = (mq.size() == 0);
                if ((m_mode == M_RUN || m_mode == M_DRAIN) && !empty && mq[0].due == cyc) begin
                    b = mq.pop_front();
                    e = 0; fl = -1;
                    for (int k = 0; k < W; k++) begin
                        if (in_half(b.wrh, b.ln, k) && lane(b.d, k) != lane(b.r, k)) begin
                            e++;
                            if (fl < 0) fl = k;
                        end
                    end
                    if (e > 0) begin
                        if (!m_err) begin
                            m_fbeat = m_chk; m_flane = fl; m_ldut = b.d; m_lref = b.r;
                        end
                        m_err = 1'b1;
                        if (i_stop_on_err) halt = 1'b1;
                    end
                    m_chk++;
                    m_errc += e;
                end
                case (m_mode)
                    M_RUN: begin
                        if (i_wr && !halt) begin
                            b.d = i_dut; b.r = tb_ref_now; b.wrh = i_wrh; b.ln = i_wrh_l_n;
                            b.due = cyc + LAT + 1;
                            mq.push_back(b);
                        end
                        if (halt) begin m_mode = M_HALT; mq.delete(); end
                        else if (i_end) m_mode = M_DRAIN;
                    end
                    M_DRAIN: begin
                        if (halt) begin m_mode = M_HALT; mq.delete(); end
                        else if (empty) m_mode = M_DONE;
                    end
                    default: begin
                        if (i_start) begin
                            m_mode = M_RUN; m_chk = 0; m_errc = 0; m_fbeat = 0; m_flane = 0;
                            m_err = 1'b0; m_ldut = '0; m_lref = '0;
                            mq.delete();
                        end
                    end
                endcase
            end
        end
    end

    task automatic compare_all();
        check("busy_a",  64'(o_busy_a),  64'(m_mode == M_RUN || m_mode == M_DRAIN));
        check("done_a",  64'(o_done_a),  64'(m_mode == M_DONE));
        check("halt_a",  64'(o_halt_a),  64'(m_mode == M_HALT));
        check("err_a",   64'(o_err_a),   64'(m_err));
        check("chk_a",   64'(o_chk_a),   sat(m_chk, CWA));
        check("errc_a",  64'(o_errc_a),  sat(m_errc, CWA));
        check("fbeat_a", 64'(o_fbeat_a), sat(m_fbeat, CWA));
        check("flane_a", 64'(o_flane_a), 64'(m_flane));
        check("ldut_a",  64'(o_ldut_a),  exp_log(m_ldut));
        check("lref_a",  64'(o_lref_a),  exp_log(m_lref));
        check("busy_b",  64'(o_busy_b),  64'(m_mode == M_RUN || m_mode == M_DRAIN));
        check("done_b",  64'(o_done_b),  64'(m_mode == M_DONE));
        check("halt_b",  64'(o_halt_b),  64'(m_mode == M_HALT));
        check("err_b",   64'(o_err_b),   64'(m_err));
        check("chk_b",   64'(o_chk_b),   sat(m_chk, CWB));
        check("errc_b",  64'(o_errc_b),  sat(m_errc, CWB));
        check("fbeat_b", 64'(o_fbeat_b), sat(m_fbeat, CWB));
        check("flane_b", 64'(o_flane_b), 64'(m_flane));
        check("ldut_b",  64'(o_ldut_b),  exp_log(m_ldut));
        check("lref_b",  64'(o_lref_b),  exp_log(m_lref));
    endtask

    always @(negedge ck) compare_all();

    // ---------------- stimulus ----------------
    task automatic drive(input logic st, input logic en, input logic wr, input logic wrh,
                         input logic ln, input logic [DW-1:0] d, input logic [DW-1:0] r);
        @(negedge ck);
        i_start = st; i_end = en; i_wr = wr; i_wrh = wrh; i_wrh_l_n = ln; i_dut = d;
        i_ref = ref_pipe;
        ref_pipe = r;
        tb_ref_now = r;
    endtask

    task automatic idle1();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
    endtask

    task automatic start1();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
    endtask

    task automatic wait_end(input string nm);
        int k;
        k = 0;
        while (!(o_done_a || o_halt_a) && k < 20) begin
            idle1();
            k++;
        end
        check({nm, "_timeout"}, 64'(k < 20), 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected summary before timeout");
        $fatal(1);
    end

    initial begin : stim
        logic [DW-1:0] d, r, bd, br;
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        idle1();
        check("rst_busy", 64'(o_busy_a), 64'd0);

        // 16 clean words; a stray i_start mid-run must be ignored
        start1();
        for (int i = 0; i < 16; i++) begin
            d = DW'($urandom);
            drive(i == 8, i == 15, 1'b1, 1'b0, 1'b0, d, d);
        end
        wait_end("A");
        check("A_chk",  64'(o_chk_a),  64'd16);
        check("A_errc", 64'(o_errc_a), 64'd0);
        check("A_done", 64'(o_done_a), 64'd1);
        check("A_err",  64'(o_err_a),  64'd0);
        check("A_chkb", 64'(o_chk_b),  64'd15);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h8765_4321);
        idle1(); idle1(); idle1();
        check("A_chk_idle", 64'(o_chk_a), 64'd16);

        // word 5: lanes 2 and 6 wrong, continue on error
        i_stop_on_err = 1'b0;
        start1();
        bd = '0; br = '0;
        for (int i = 0; i < 16; i++) begin
            r = DW'($urandom);
            d = (i == 5) ? (r ^ 32'h00F0_00F0) : r;
            if (i == 5) begin bd = d; br = r; end
            drive(1'b0, i == 15, 1'b1, 1'b0, 1'b0, d, r);
            if (i == 7) check("B_err_early", 64'(o_err_a), 64'd0);
            if (i == 8) check("B_err_t2",    64'(o_err_a), 64'd1);
        end
        wait_end("B");
        check("B_errc",  64'(o_errc_a),  64'd2);
        check("B_fbeat", 64'(o_fbeat_a), 64'd5);
        check("B_flane", 64'(o_flane_a), 64'd2);
        check("B_chk",   64'(o_chk_a),   64'd16);
        check("B_done",  64'(o_done_a),  64'd1);
        check("B_ldut",  64'(o_ldut_a),  exp_log(bd));
        check("B_lref",  64'(o_lref_a),  exp_log(br));

        // half-word writes: lanes 0..3 wrong
        start1();
        r = DW'($urandom);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, r ^ 32'hFFFF_0000, r);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, r ^ 32'hFFFF_0000, r);
        wait_end("C");
        check("C_chk",   64'(o_chk_a),   64'd2);
        check("C_errc",  64'(o_errc_a),  64'd4);
        check("C_fbeat", 64'(o_fbeat_a), 64'd1);
        check("C_flane", 64'(o_flane_a), 64'd0);

        // stop on error at beat 3, lane 5
        i_stop_on_err = 1'b1;
        start1();
        for (int i = 0; i < 8; i++) begin
            r = DW'($urandom);
            d = (i == 3) ? (r ^ 32'h0000_0F00) : r;
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d, r);
        end
        wait_end("D");
        check("D_halt",  64'(o_halt_a),  64'd1);
        check("D_busy",  64'(o_busy_a),  64'd0);
        check("D_chk",   64'(o_chk_a),   64'd4);
        check("D_errc",  64'(o_errc_a),  64'd1);
        check("D_fbeat", 64'(o_fbeat_a), 64'd3);
        check("D_flane", 64'(o_flane_a), 64'd5);
        start1();
        idle1();
        check("D_rearm_busy", 64'(o_busy_a), 64'd1);
        check("D_rearm_halt", 64'(o_halt_a), 64'd0);
        check("D_rearm_chk",  64'(o_chk_a),  64'd0);
        check("D_rearm_errc", 64'(o_errc_a), 64'd0);
        check("D_rearm_err",  64'(o_err_a),  64'd0);
        for (int i = 0; i < 3; i++) begin
            d = DW'($urandom);
            drive(1'b0, i == 2, 1'b1, 1'b0, 1'b0, d, d);
        end
        wait_end("D2");
        check("D2_done", 64'(o_done_a), 64'd1);
        check("D2_chk",  64'(o_chk_a),  64'd3);

        // 20 words, words 10..19 fully wrong: saturation on the narrow instance
        i_stop_on_err = 1'b0;
        start1();
        for (int i = 0; i < 20; i++) begin
            r = DW'($urandom);
            d = (i >= 10) ? ~r : r;
            if (i == 10) begin bd = d; br = r; end
            drive(1'b0, i == 19, 1'b1, 1'b0, 1'b0, d, r);
        end
        wait_end("F");
        check("F_chk_a",   64'(o_chk_a),   64'd20);
        check("F_chk_b",   64'(o_chk_b),   64'd15);
        check("F_errc_a",  64'(o_errc_a),  64'd80);
        check("F_errc_b",  64'(o_errc_b),  64'd15);
        check("F_fbeat_b", 64'(o_fbeat_b), 64'd10);
        check("F_flane_b", 64'(o_flane_b), 64'd0);
        check("F_ldut_b",  64'(o_ldut_b),  exp_log(bd));
        check("F_lref_b",  64'(o_lref_b),  exp_log(br));

        // asynchronous reset in the middle of a run with an error recorded
        start1();
        for (int i = 0; i < 4; i++) begin
            r = DW'($urandom);
            d = (i == 1) ? (r ^ 32'hF000_0000) : r;
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d, r);
        end
        idle1(); idle1(); idle1();
        check("E_err_pre",  64'(o_err_a),  64'd1);
        check("E_busy_pre", 64'(o_busy_a), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("E_busy",  64'(o_busy_a | o_busy_b), 64'd0);
        check("E_done",  64'(o_done_a | o_done_b), 64'd0);
        check("E_halt",  64'(o_halt_a | o_halt_b), 64'd0);
        check("E_err",   64'(o_err_a | o_err_b),   64'd0);
        check("E_chk",   64'(o_chk_a),   64'd0);
        check("E_errc",  64'(o_errc_a),  64'd0);
        check("E_fbeat", 64'(o_fbeat_a), 64'd0);
        check("E_flane", 64'(o_flane_a), 64'd0);
        check("E_ldut",  64'(o_ldut_a),  64'd0);
        check("E_chk_b", 64'(o_chk_b),   64'd0);
        @(negedge ck);
        rst_n = 1'b1;
        idle1();
        check("E_idle_busy", 64'(o_busy_a), 64'd0);
        start1();
        for (int i = 0; i < 2; i++) begin
            d = DW'($urandom);
            drive(1'b0, i == 1, 1'b1, 1'b0, 1'b0, d, d);
        end
        wait_end("E2");
        check("E2_chk", 64'(o_chk_a), 64'd2);
        idle1();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
